// File: rtl/board_pkg.sv
// Shared board geometry defaults, ASCII codes and the loader state encoding
// used by the board ingest and printout paths.
package board_pkg;

    localparam int DEFAULT_LOG_WIDTH  = 5;
    localparam int DEFAULT_LOG_HEIGHT = 4;

    localparam logic [7:0] CHAR_LF    = 8'd10;
    localparam logic [7:0] CHAR_CR    = 8'd13;
    localparam logic [7:0] CHAR_ESC   = 8'd27;
    localparam logic [7:0] CHAR_SPACE = 8'd32;
    localparam logic [7:0] CHAR_HASH  = 8'd35;
    localparam logic [7:0] CHAR_STAR  = 8'd42;
    localparam logic [7:0] CHAR_DOT   = 8'd46;
    localparam logic [7:0] CHAR_O     = 8'd79;
    localparam logic [7:0] CHAR_TILDE = 8'd126;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKIP,
        ST_PAD,
        ST_DONE
    } loader_state_t;

    typedef enum logic [2:0] {
        CC_IGNORE,
        CC_ALIVE,
        CC_DEAD,
        CC_NEWLINE,
        CC_ABORT
    } char_class_t;

endpackage

// File: rtl/cell_char_decode.sv
// Combinational byte classifier for board text: alive, dead, newline, abort
// or ignore. CR falls into ignore so CR LF and bare LF line endings both work.
module cell_char_decode
    import board_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_t cls
);

    always_comb begin
        cls = CC_IGNORE;
        if (ch == CHAR_O || ch == CHAR_HASH || ch == CHAR_STAR)
            cls = CC_ALIVE;
        else if (ch == CHAR_LF)
            cls = CC_NEWLINE;
        else if (ch == CHAR_ESC)
            cls = CC_ABORT;
        else if (ch == CHAR_SPACE || ch == CHAR_DOT || (ch > CHAR_SPACE && ch <= CHAR_TILDE))
            cls = CC_DEAD;
    end

endmodule

// File: rtl/board_loader.sv
// board_loader: parses terminal text rows into row-major Game-of-Life cell writes.
// Define BOARD_LOADER_TIMEOUT_EN to build the idle-gap abort counter.
module board_loader
    import board_pkg::*;
#(
    parameter int LOG_WIDTH      = DEFAULT_LOG_WIDTH,
    parameter int LOG_HEIGHT     = DEFAULT_LOG_HEIGHT,
    parameter int TIMEOUT_CYCLES = 48000000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic                            wr_en,
    output logic [LOG_WIDTH+LOG_HEIGHT-1:0] wr_addr,
    output logic                            wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err
);

    // state | meaning
    // IDLE  | waiting for start; bytes stay pending upstream
    // LOAD  | consuming row text, one cell write per printable byte
    // SKIP  | row full; discarding bytes until LF
    // PAD   | short row; writing dead cells up to the row end
    // DONE  | all rows written; one-cycle done pulse

    localparam logic [LOG_WIDTH:0]  WIDTH_C  = {1'b1, {LOG_WIDTH{1'b0}}};
    localparam logic [LOG_HEIGHT:0] HEIGHT_C = {1'b1, {LOG_HEIGHT{1'b0}}};

    loader_state_t                   state, state_d;
    logic [LOG_HEIGHT:0]             row, row_d, row_inc;
    logic [LOG_WIDTH:0]              col, col_d, col_inc;
    logic [LOG_WIDTH+LOG_HEIGHT-1:0] wr_addr_d, cell_addr;
    logic                            wr_en_d, wr_data_d, busy_d, ready_d, done_d, err_d;
    logic                            accept, timeout;
    char_class_t                     cls;

    cell_char_decode u_decode (
        .ch  (rx_data),
        .cls (cls)
    );

    assign accept    = rx_valid && rx_ready;
    assign row_inc   = row + 1'b1;
    assign col_inc   = col + 1'b1;
    assign cell_addr = {row[LOG_HEIGHT-1:0], col[LOG_WIDTH-1:0]};

`ifdef BOARD_LOADER_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] GAP_RELOAD = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] gap_cnt;

    // rx_ready mirrors LOAD/SKIP, so the counter is parked at reload elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gap_cnt <= GAP_RELOAD;
        else if (!rx_ready || accept)
            gap_cnt <= GAP_RELOAD;
        else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
    end

    assign timeout = rx_ready && !accept && (gap_cnt == '0);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        row_d     = row;
        col_d     = col;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr;
        wr_data_d = wr_data;
        err_d     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    case (cls)
                        CC_ALIVE, CC_DEAD: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cell_addr;
                            wr_data_d = (cls == CC_ALIVE);
                            col_d     = col_inc;
                            if (col_inc == WIDTH_C)
                                state_d = ST_SKIP;
                        end
                        CC_NEWLINE: begin
                            // first pad cell goes out with the LF so rx_ready
                            // returns exactly one cycle after the last pad write
                            if (col != '0) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cell_addr;
                                wr_data_d = 1'b0;
                                col_d     = col_inc;
                                state_d   = ST_PAD;
                            end
                        end
                        CC_ABORT: begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: ;
                    endcase
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SKIP: begin
                if (accept) begin
                    if (cls == CC_NEWLINE) begin
                        row_d   = row_inc;
                        col_d   = '0;
                        state_d = (row_inc == HEIGHT_C) ? ST_DONE : ST_LOAD;
                    end else if (cls == CC_ABORT) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PAD: begin
                if (col == WIDTH_C) begin
                    row_d   = row_inc;
                    col_d   = '0;
                    state_d = (row_inc == HEIGHT_C) ? ST_DONE : ST_LOAD;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cell_addr;
                    wr_data_d = 1'b0;
                    col_d     = col_inc;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_LOAD) || (state_d == ST_SKIP) || (state_d == ST_PAD);
        ready_d = (state_d == ST_LOAD) || (state_d == ST_SKIP);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            row      <= row_d;
            col      <= col_d;
            rx_ready <= ready_d;
            wr_en    <= wr_en_d;
            wr_addr  <= wr_addr_d;
            wr_data  <= wr_data_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader: full board, short/long lines, noise, abort,
// mid-load reset, and the idle timeout when BOARD_LOADER_TIMEOUT_EN is defined.
module tb_board_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready, wr_en, wr_data, busy, done, err;
    logic [8:0] wr_addr;

    board_loader #(.TIMEOUT_CYCLES(100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [9:0] wq[$];
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, acc_cnt = 0;

    always @(negedge clk) begin
        if (wr_en) wq.push_back({wr_data, wr_addr});
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (rx_valid && rx_ready) acc_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the falling edge, clear of both edges
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        wq.delete();
        done_cnt = 0; err_cnt = 0; acc_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) chk("rx_ready_wait", {31'd0, rx_ready}, 1);
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] abort_char(input int k);
        if (k % 2 == 0) begin
            case ((k / 2) % 3)
                0:       return 8'h4F;
                1:       return 8'h23;
                default: return 8'h2A;
            endcase
        end
        return ((k / 2) % 2 == 0) ? 8'h20 : 8'h2E;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its cycle budget");
        $fatal(1);
    end

    initial begin
        int errs, npad, k, sz;
        logic [9:0] e;

        // reset values and idle behaviour
        tick();
        chk("rst_outputs", {rx_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);
        do_reset();
        rx_data = 8'h4F; rx_valid = 1'b1;
        repeat (5) tick();
        chk("idle_no_accept", acc_cnt, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        rx_valid = 1'b0;

        // full board of 'O'
        pulse_start();
        chk("start_busy", {31'd0, busy}, 1);
        chk("start_ready", {31'd0, rx_ready}, 1);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 32; c++) send_byte(8'h4F);
            send_byte(8'd13);
            send_byte(8'd10);
        end
        chk("full_done_now", {31'd0, done}, 1);
        chk("full_busy_low", {31'd0, busy}, 0);
        tick();
        chk("full_done_pulse", {31'd0, done}, 0);
        chk("full_writes", wq.size(), 512);
        errs = 0;
        for (int i = 0; i < wq.size(); i++) begin
            e = wq[i];
            if (e[8:0] != 9'(i) || e[9] != 1'b1) errs++;
        end
        chk("full_order", errs, 0);
        chk("full_done_cnt", done_cnt, 1);
        chk("full_err_cnt", err_cnt, 0);

        // short line "O.O" LF then padding
        do_reset();
        pulse_start();
        send_byte(8'h4F); send_byte(8'h2E); send_byte(8'h4F); send_byte(8'd10);
        npad = 0; k = 0;
        while (!rx_ready && k < 100) begin
            if (wr_en) npad++;
            tick();
            k++;
        end
        chk("short_pad_writes", npad, 29);
        chk("short_ready_low", k, 29);
        chk("short_writes", wq.size(), 32);
        errs = 0;
        for (int i = 0; i < wq.size(); i++) begin
            e = wq[i];
            if (e[8:0] != 9'(i) || e[9] != (i == 0 || i == 2)) errs++;
        end
        chk("short_cells", errs, 0);
        send_byte(8'h4F);
        e = wq[wq.size() - 1];
        chk("short_next_addr", {23'd0, e[8:0]}, 32);

        // long line, noise, start while busy, empty line
        do_reset();
        pulse_start();
        repeat (40) send_byte(8'h4F);
        send_byte(8'd10);
        chk("long_writes", wq.size(), 32);
        errs = 0;
        for (int i = 0; i < wq.size(); i++) begin
            e = wq[i];
            if (e[8:0] != 9'(i) || e[9] != 1'b1) errs++;
        end
        chk("long_order", errs, 0);
        chk("long_accepted", acc_cnt, 41);
        pulse_start();
        chk("busy_start_ignored", {31'd0, busy}, 1);
        send_byte(8'd13); send_byte(8'h07); send_byte(8'hFF); send_byte(8'd10);
        chk("noise_no_write", wq.size(), 32);
        send_byte(8'h4F);
        chk("noise_writes", wq.size(), 33);
        e = wq[wq.size() - 1];
        chk("empty_line_no_adv", {23'd0, e[8:0]}, 32);
        chk("noise_accepted", acc_cnt, 46);

        // abort after 100 cell bytes
        do_reset();
        pulse_start();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 32; c++) send_byte(abort_char(32 * r + c));
            send_byte(8'd10);
        end
        for (int c = 0; c < 4; c++) send_byte(abort_char(96 + c));
        send_byte(8'd27);
        chk("abort_err_now", {31'd0, err}, 1);
        chk("abort_busy_low", {31'd0, busy}, 0);
        rx_data = 8'h4F; rx_valid = 1'b1;
        repeat (10) tick();
        chk("abort_ready_low", {31'd0, rx_ready}, 0);
        rx_valid = 1'b0;
        chk("abort_writes", wq.size(), 100);
        errs = 0;
        for (int i = 0; i < wq.size(); i++) begin
            e = wq[i];
            if (e[8:0] != 9'(i) || e[9] != ((i % 2) == 0)) errs++;
        end
        chk("abort_cells", errs, 0);
        chk("abort_err_cnt", err_cnt, 1);

        // reset while padding
        do_reset();
        pulse_start();
        send_byte(8'h4F);
        send_byte(8'd10);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {rx_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);
        sz = wq.size();
        tick();
        chk("midrst_next", {rx_ready, wr_en, wr_addr, wr_data, busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("midrst_no_writes", wq.size(), sz);
        pulse_start();
        send_byte(8'h4F);
        e = wq[wq.size() - 1];
        chk("midrst_restart_addr", {23'd0, e[8:0]}, 0);
        chk("midrst_restart_data", {31'd0, e[9]}, 1);

`ifdef BOARD_LOADER_TIMEOUT_EN
        do_reset();
        pulse_start();
        send_byte(8'h4F);
        repeat (3) begin
            repeat (98) tick();
            send_byte(8'h2E);
        end
        chk("to_gap99_no_err", err_cnt, 0);
        k = 0;
        while (!err && k < 150) begin
            tick();
            k++;
        end
        chk("to_fires", {31'd0, err}, 1);
        chk("to_latency", k, 100);
        chk("to_busy_low", {31'd0, busy}, 0);
`endif

        chk("done_err_excl", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
